// File: rtl/er_mon_pkg.sv
// Shared encodings for the executable-region monitor.
// State and violation-cause codes used by every region FSM.
package er_mon_pkg;

  typedef enum logic {
    ABORT = 1'b0,
    EXEC  = 1'b1
  } state_e;

  typedef enum logic [1:0] {
    C_NONE = 2'd0,
    C_IRQ  = 2'd1,
    C_DMA  = 2'd2,
    C_CF   = 2'd3
  } cause_e;

endpackage

// File: rtl/er_region_fsm.sv
// One executable region: bounds match, violation detect,
// and the ABORT/EXEC attestation state machine.
module er_region_fsm
  import er_mon_pkg::*;
#(
  parameter int AW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] pc,
  input  logic [AW-1:0] prev_pc,
  input  logic          irq,
  input  logic          dma_en,
  input  logic [AW-1:0] dma_addr,
  input  logic [AW-1:0] er_min,
  input  logic [AW-1:0] er_max,
  input  logic          er_valid,
  output logic          exec,
  output logic          viol,
  output logic          viol_nxt,
  output logic [1:0]    cause
);

  state_e state, state_nxt;
  cause_e cause_q, cause_nxt;
  logic   prev_in;
  logic   in_er, dma_hit;
  logic   v_irq, v_dma, v_cf, any_v;

  // Inverted bounds never match because both compares must hold.
  assign in_er   = er_valid && (er_min <= pc) && (pc <= er_max);
  assign dma_hit = dma_en && er_valid &&
                   (er_min <= dma_addr) && (dma_addr <= er_max);

  assign v_irq = in_er && irq;
  assign v_dma = dma_hit || (dma_en && in_er);
  assign v_cf  = (!prev_in && in_er && (pc != er_min)) ||
                 (prev_in && !in_er && (prev_pc != er_max));
  assign any_v = v_irq || v_dma || v_cf;

  always_comb begin
    state_nxt = state;
    cause_nxt = cause_q;
    viol_nxt  = 1'b0;
    unique case (state)
      ABORT: begin
        if (in_er && (pc == er_min) && !any_v)
          state_nxt = EXEC;
      end
      EXEC: begin
        // Disabling a region drops attestation silently.
        if (!er_valid) begin
          state_nxt = ABORT;
        end else if (any_v) begin
          state_nxt = ABORT;
          viol_nxt  = 1'b1;
          cause_nxt = v_irq ? C_IRQ :
                      v_dma ? C_DMA : C_CF;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ABORT;
      cause_q <= C_NONE;
      viol    <= 1'b0;
      prev_in <= 1'b0;
    end else begin
      state   <= state_nxt;
      cause_q <= cause_nxt;
      viol    <= viol_nxt;
      prev_in <= in_er;
    end
  end

  assign exec  = (state == EXEC);
  assign cause = cause_q;

endmodule

// File: rtl/er_exec_monitor.sv
// Executable-region monitor: N_ER independent region FSMs,
// shared prev_pc history and a saturating violation counter.
module er_exec_monitor
  import er_mon_pkg::*;
#(
  parameter int N_ER = 2,
  parameter int AW   = 16,
  parameter int CW   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [AW-1:0]    pc,
  input  logic             irq,
  input  logic             dma_en,
  input  logic [AW-1:0]    dma_addr,
  input  logic [N_ER*AW-1:0] er_min,
  input  logic [N_ER*AW-1:0] er_max,
  input  logic [N_ER-1:0]  er_valid,
  output logic [N_ER-1:0]  exec,
  output logic [N_ER-1:0]  viol,
  output logic [2*N_ER-1:0] cause,
  output logic [CW-1:0]    viol_cnt
);

  logic [AW-1:0]   prev_pc;
  logic [N_ER-1:0] viol_nxt;

  for (genvar i = 0; i < N_ER; i++) begin : g_er
    er_region_fsm #(.AW(AW)) u_fsm (
      .clk      (clk),
      .rst      (rst),
      .pc       (pc),
      .prev_pc  (prev_pc),
      .irq      (irq),
      .dma_en   (dma_en),
      .dma_addr (dma_addr),
      .er_min   (er_min[i*AW +: AW]),
      .er_max   (er_max[i*AW +: AW]),
      .er_valid (er_valid[i]),
      .exec     (exec[i]),
      .viol     (viol[i]),
      .viol_nxt (viol_nxt[i]),
      .cause    (cause[2*i +: 2])
    );
  end

  // Count on the same edge that raises viol, one step per cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_pc  <= '0;
      viol_cnt <= '0;
    end else begin
      prev_pc <= pc;
      if ((|viol_nxt) && (viol_cnt != {CW{1'b1}}))
        viol_cnt <= viol_cnt + CW'(1);
    end
  end

endmodule

// File: tb/tb_er_exec_monitor.sv
// Directed self-checking bench for er_exec_monitor
// (N_ER=2, AW=16, CW=2).
module tb_er_exec_monitor;

  localparam int N_ER = 2;
  localparam int AW   = 16;
  localparam int CW   = 2;

  logic                 clk;
  logic                 rst;
  logic [AW-1:0]        pc;
  logic                 irq;
  logic                 dma_en;
  logic [AW-1:0]        dma_addr;
  logic [N_ER*AW-1:0]   er_min;
  logic [N_ER*AW-1:0]   er_max;
  logic [N_ER-1:0]      er_valid;
  logic [N_ER-1:0]      exec;
  logic [N_ER-1:0]      viol;
  logic [2*N_ER-1:0]    cause;
  logic [CW-1:0]        viol_cnt;

  int total = 0;
  int bad   = 0;

  er_exec_monitor #(.N_ER(N_ER), .AW(AW), .CW(CW)) dut (
    .clk      (clk),
    .rst      (rst),
    .pc       (pc),
    .irq      (irq),
    .dma_en   (dma_en),
    .dma_addr (dma_addr),
    .er_min   (er_min),
    .er_max   (er_max),
    .er_valid (er_valid),
    .exec     (exec),
    .viol     (viol),
    .cause    (cause),
    .viol_cnt (viol_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst      = 1'b1;
    pc       = '0;
    irq      = 1'b0;
    dma_en   = 1'b0;
    dma_addr = '0;
    er_min   = {16'hF000, 16'hE000};
    er_max   = {16'hF01F, 16'hE0FF};
    er_valid = 2'b11;
    #1;
    chk("rst_exec",  32'(exec),     32'h0);
    chk("rst_viol",  32'(viol),     32'h0);
    chk("rst_cause", 32'(cause),    32'h0);
    chk("rst_cnt",   32'(viol_cnt), 32'h0);
    tick();
    rst = 1'b0;
    tick();

    // Legal entry, walk, legal exit
    pc = 16'hE000; tick();
    chk("entry_exec", 32'(exec), 32'h1);
    for (int a = 16'hE002; a <= 16'hE0FF; a++) begin
      pc = 16'(a);
      tick();
    end
    chk("walk_exec", 32'(exec), 32'h1);
    pc = 16'hE100; tick();
    chk("exit_exec", 32'(exec), 32'h1);
    chk("exit_viol", 32'(viol), 32'h0);

    // IRQ and DMA together inside R0: IRQ wins
    pc = 16'hE000; tick();
    chk("reentry_exec", 32'(exec), 32'h1);
    pc = 16'hE010; irq = 1'b1; dma_en = 1'b1; dma_addr = 16'h0000;
    tick();
    chk("irq_exec",  32'(exec),     32'h0);
    chk("irq_viol",  32'(viol),     32'h1);
    chk("irq_cause", 32'(cause),    32'h1);
    chk("irq_cnt",   32'(viol_cnt), 32'h1);
    irq = 1'b0; dma_en = 1'b0;
    pc = 16'hE011; tick();
    chk("irq_pulse_end", 32'(viol), 32'h0);
    chk("abort_hold",    32'(exec), 32'h0);

    // DMA into region from outside
    pc = 16'hE000; tick();
    pc = 16'hE0FF; tick();
    pc = 16'hE100; tick();
    chk("pre_dma_exec", 32'(exec), 32'h1);
    dma_en = 1'b1; dma_addr = 16'hE0FF; tick();
    chk("dma_exec",  32'(exec),     32'h0);
    chk("dma_viol",  32'(viol),     32'h1);
    chk("dma_cause", 32'(cause),    32'h2);
    chk("dma_cnt",   32'(viol_cnt), 32'h2);
    dma_en = 1'b0;
    pc = 16'hE000; tick();
    chk("dma_reenter", 32'(exec), 32'h1);
    pc = 16'hE0FF; tick();
    pc = 16'hE100; tick();
    dma_en = 1'b1; dma_addr = 16'hE100; tick();
    chk("dma_miss_exec",  32'(exec),  32'h1);
    chk("dma_miss_viol",  32'(viol),  32'h0);
    chk("dma_miss_cause", 32'(cause), 32'h2);
    dma_en = 1'b0;

    // Disable drops EXEC without a pulse
    er_valid = 2'b10; tick();
    chk("dis_exec",  32'(exec),  32'h0);
    chk("dis_viol",  32'(viol),  32'h0);
    chk("dis_cause", 32'(cause), 32'h2);
    er_valid = 2'b11;

    // Illegal entry from ABORT: no pulse
    pc = 16'h1000; tick();
    pc = 16'hE004; tick();
    chk("bad_entry_exec",  32'(exec),  32'h0);
    chk("bad_entry_viol",  32'(viol),  32'h0);
    chk("bad_entry_cause", 32'(cause), 32'h2);

    // Illegal exit from EXEC
    pc = 16'hE000; tick();
    pc = 16'hE050; tick();
    chk("pre_cf_exec", 32'(exec), 32'h1);
    pc = 16'h2000; tick();
    chk("cf_exec",  32'(exec),     32'h0);
    chk("cf_viol",  32'(viol),     32'h1);
    chk("cf_cause", 32'(cause),    32'h3);
    chk("cf_cnt",   32'(viol_cnt), 32'h3);

    // Counter saturation with overlapping regions
    rst = 1'b1; #1;
    chk("rst2_cnt", 32'(viol_cnt), 32'h0);
    er_min = {16'hE000, 16'hE000};
    er_max = {16'hE01F, 16'hE0FF};
    pc = '0;
    tick();
    rst = 1'b0;
    tick();
    for (int k = 1; k <= 5; k++) begin
      pc = 16'hE000; irq = 1'b0; tick();
      chk("sat_enter", 32'(exec), 32'h3);
      pc = 16'hE010; irq = 1'b1; tick();
      chk("sat_viol", 32'(viol), 32'h3);
      chk("sat_cnt", 32'(viol_cnt), 32'((k > 3) ? 3 : k));
    end
    chk("both_cause", 32'(cause), 32'h5);
    irq = 1'b0;

    // Inverted bounds never match
    er_min = {16'hF010, 16'hE000};
    er_max = {16'hF000, 16'hE0FF};
    pc = 16'hF010; tick();
    chk("inv_exec", 32'(exec), 32'h0);
    chk("inv_viol", 32'(viol), 32'h0);

    // Async reset mid-EXEC
    pc = 16'hE000; tick();
    chk("pre_rst_exec", 32'(exec), 32'h1);
    #2 rst = 1'b1;
    #1;
    chk("arst_exec",  32'(exec),     32'h0);
    chk("arst_viol",  32'(viol),     32'h0);
    chk("arst_cause", 32'(cause),    32'h0);
    chk("arst_cnt",   32'(viol_cnt), 32'h0);
    tick();
    rst = 1'b0;
    tick();
    chk("post_rst_viol", 32'(viol), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
